// File: rtl/seg7_digit_driver.sv
// seg7_digit_driver
//
// Drives a 4-digit multiplexed seven-segment display from the rotating
// active-low one-hot digit select produced by the scan stage.
//   - The 16-bit value and the decimal points are double-buffered. A load
//     fills the pending buffer, and that buffer is committed to the active
//     buffer only when the scan wraps to digit0. A frame therefore never
//     shows a mix of old and new digits.
//   - Segments follow the select with one edge of latency. The anodes are
//     held off for BLANK_CYCLES edges after every select change, so the
//     segments settle while the digit is dark and do not ghost.
//
// Ports
//   clk        scan clock, shared with the digit scan stage
//   rst        asynchronous, active-high reset
//   digit_sel  active-low one-hot select (1110 = digit0 = value[3:0])
//   value      hex value to display, digit3 = value[15:12]
//   dp_in      decimal point enables, active-high, bit i = digit i
//   load       single-cycle strobe that captures value/dp_in into pending
//   an         anode drive, active-low, registered
//   seg        segments {g,f,e,d,c,b,a}, active-low, registered
//   dp         decimal point, active-low, registered
//
// Parameter
//   BLANK_CYCLES  edges the anodes stay off after a select change (0 = none)
//
// Build option
//   LEADING_ZERO_BLANK_EN  when defined, digits 3..1 are blanked while their
//                          nibble and every higher nibble are zero
module seg7_digit_driver #(
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  digit_sel,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    // The counter only ever holds values up to BLANK_CYCLES-1.
    localparam int CW = (BLANK_CYCLES > 2) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [CW-1:0] BLANK_LOAD =
        (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;

    logic [15:0]   active_val;
    logic [3:0]    active_dp;
    logic [15:0]   pend_val;
    logic [3:0]    pend_dp;
    logic          pend;
    logic [3:0]    prev_sel;
    logic [CW-1:0] blank_cnt;

    logic          sel_valid;
    logic [1:0]    digit_idx;
    logic          change;
    logic          commit;
    logic [15:0]   next_val;
    logic [3:0]    next_dp;
    logic [3:0]    nibble;
    logic          lz_blank;
    logic [6:0]    seg_dec;

    // Classify the select. Anything other than exactly one low bit is
    // invalid and darkens the whole display.
    always_comb begin
        sel_valid = 1'b1;
        digit_idx = 2'd0;
        case (digit_sel)
            4'b1110: digit_idx = 2'd0;
            4'b1101: digit_idx = 2'd1;
            4'b1011: digit_idx = 2'd2;
            4'b0111: digit_idx = 2'd3;
            default: sel_valid = 1'b0;
        endcase
    end

    assign change = (digit_sel != prev_sel);
    assign commit = sel_valid && (digit_sel == 4'b1110) && (prev_sel != 4'b1110);

    // Decode from the buffer as it will be after this edge, so the digit0
    // shown on the commit edge already comes from the new frame.
    assign next_val = (commit && pend) ? pend_val : active_val;
    assign next_dp  = (commit && pend) ? pend_dp  : active_dp;
    assign nibble   = next_val[{digit_idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        lz_blank = 1'b0;
        case (digit_idx)
            2'd3:    lz_blank = (next_val[15:12] == 4'h0);
            2'd2:    lz_blank = (next_val[15:8]  == 8'h00);
            2'd1:    lz_blank = (next_val[15:4]  == 12'h000);
            default: lz_blank = 1'b0;
        endcase
    end
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        seg_dec = 7'b1111111;
        case (nibble)
            4'h0: seg_dec = 7'b1000000;
            4'h1: seg_dec = 7'b1111001;
            4'h2: seg_dec = 7'b0100100;
            4'h3: seg_dec = 7'b0110000;
            4'h4: seg_dec = 7'b0011001;
            4'h5: seg_dec = 7'b0010010;
            4'h6: seg_dec = 7'b0000010;
            4'h7: seg_dec = 7'b1111000;
            4'h8: seg_dec = 7'b0000000;
            4'h9: seg_dec = 7'b0010000;
            4'hA: seg_dec = 7'b0001000;
            4'hB: seg_dec = 7'b0000011;
            4'hC: seg_dec = 7'b1000110;
            4'hD: seg_dec = 7'b0100001;
            4'hE: seg_dec = 7'b0000110;
            4'hF: seg_dec = 7'b0001110;
            default: seg_dec = 7'b1111111;
        endcase
    end

    // Double buffer. When a load lands on the commit edge, active takes the
    // old pending contents and the new load stays pending for next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_val <= '0;
            active_dp  <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend       <= 1'b0;
        end else begin
            active_val <= next_val;
            active_dp  <= next_dp;
            if (load) begin
                pend_val <= value;
                pend_dp  <= dp_in;
                pend     <= 1'b1;
            end else if (commit) begin
                pend     <= 1'b0;
            end
        end
    end

    // Anti-ghosting window and output registers. A change restarts the
    // window; the anodes come back on the first edge after it has expired.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_sel  <= 4'b1111;
            blank_cnt <= '0;
            an        <= 4'b1111;
            seg       <= 7'b1111111;
            dp        <= 1'b1;
        end else begin
            prev_sel <= digit_sel;

            if (change && (BLANK_CYCLES > 0)) begin
                blank_cnt <= BLANK_LOAD;
                an        <= 4'b1111;
            end else if (blank_cnt != '0) begin
                blank_cnt <= blank_cnt - 1'b1;
                an        <= 4'b1111;
            end else begin
                an        <= sel_valid ? digit_sel : 4'b1111;
            end

            if (sel_valid) begin
                seg <= lz_blank ? 7'b1111111 : seg_dec;
                dp  <= ~next_dp[digit_idx];
            end else begin
                seg <= 7'b1111111;
                dp  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_digit_driver.sv
// tb_seg7_digit_driver
//
// Drives two copies of seg7_digit_driver (BLANK_CYCLES = 4 and 0) with the
// same inputs. A frame-level model of the display is stepped on each clock
// edge and queues the expected outputs; a monitor pops and compares them on
// the falling edge.
module tb_seg7_digit_driver;

    logic        clk;
    logic        rst;
    logic [3:0]  digit_sel;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;

    logic [3:0]  an4, an0;
    logic [6:0]  seg4, seg0;
    logic        dp4, dp0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] an4;
        logic [3:0] an0;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t exp_q[$];

    // Display model state
    logic [15:0] m_act_val;
    logic [3:0]  m_act_dp;
    logic [15:0] m_pend_val;
    logic [3:0]  m_pend_dp;
    bit          m_pend;
    logic [3:0]  m_prev;
    int          m_since;

    logic [6:0] seg_table [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seg7_digit_driver #(.BLANK_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .digit_sel(digit_sel), .value(value),
        .dp_in(dp_in), .load(load), .an(an4), .seg(seg4), .dp(dp4)
    );

    seg7_digit_driver #(.BLANK_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .digit_sel(digit_sel), .value(value),
        .dp_in(dp_in), .load(load), .an(an0), .seg(seg0), .dp(dp0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [6:0] actual,
                               input logic [6:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %b, expected %b",
                     name, $time, actual, expected);
        end
    endtask

    task automatic modelReset();
        m_act_val  = '0;
        m_act_dp   = '0;
        m_pend_val = '0;
        m_pend_dp  = '0;
        m_pend     = 0;
        m_prev     = 4'b1111;
        m_since    = 0;
    endtask

    // One clock edge of the display as described at frame level: which digit
    // is selected, how long since the select last moved, what frame is live.
    task automatic modelStep(input logic [3:0] sel, input logic [15:0] val,
                             input logic [3:0] dpin, input logic ld);
        bit          valid;
        int          idx;
        logic [3:0]  onehot;
        logic [15:0] upper;
        exp_t        e;
        valid = 0;
        idx   = 0;
        for (int i = 0; i < 4; i++) begin
            onehot = 4'(1 << i);
            if (sel == ~onehot) begin
                valid = 1;
                idx   = i;
            end
        end
        if (valid && sel == 4'b1110 && m_prev != 4'b1110 && m_pend) begin
            m_act_val = m_pend_val;
            m_act_dp  = m_pend_dp;
            m_pend    = 0;
        end
        if (ld) begin
            m_pend_val = val;
            m_pend_dp  = dpin;
            m_pend     = 1;
        end
        if (sel != m_prev) m_since = 0;
        else if (m_since < 1000) m_since++;
        m_prev = sel;

        if (!valid) begin
            e.an4 = 4'b1111;
            e.an0 = 4'b1111;
            e.seg = 7'b1111111;
            e.dp  = 1'b1;
        end else begin
            upper = m_act_val >> (4 * idx);
            e.seg = seg_table[upper % 16];
`ifdef LEADING_ZERO_BLANK_EN
            if (idx > 0 && upper == 16'h0) e.seg = 7'b1111111;
`endif
            e.dp  = ~m_act_dp[idx];
            e.an4 = (m_since >= 4) ? sel : 4'b1111;
            e.an0 = sel;
        end
        exp_q.push_back(e);
    endtask

    // Present one cycle of inputs, let the edge happen, queue the expectation.
    task automatic applyStimulus(input logic [3:0] sel, input logic [15:0] val,
                                 input logic [3:0] dpin, input logic ld);
        digit_sel = sel;
        value     = val;
        dp_in     = dpin;
        load      = ld;
        @(posedge clk);
        modelStep(sel, val, dpin, ld);
        @(negedge clk);
    endtask

    task automatic holdDigit(input logic [3:0] sel, input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(sel, 16'($urandom), 4'($urandom), 1'b0);
    endtask

    task automatic fullFrame(input int n);
        holdDigit(4'b1110, n);
        holdDigit(4'b1101, n);
        holdDigit(4'b1011, n);
        holdDigit(4'b0111, n);
    endtask

    // Asynchronous reset: outputs must go dark before any clock edge.
    task automatic doReset();
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst_an_b4",  {3'b0, an4}, 7'b0001111);
        checkOutput("rst_seg_b4", seg4, 7'b1111111);
        checkOutput("rst_dp_b4",  {6'b0, dp4}, 7'b0000001);
        checkOutput("rst_an_b0",  {3'b0, an0}, 7'b0001111);
        checkOutput("rst_seg_b0", seg0, 7'b1111111);
        checkOutput("rst_dp_b0",  {6'b0, dp0}, 7'b0000001);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        modelReset();
    endtask

    // Monitor: the outputs are presented every edge; compare each one.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("an_b4",  {3'b0, an4}, {3'b0, e.an4});
                checkOutput("an_b0",  {3'b0, an0}, {3'b0, e.an0});
                checkOutput("seg_b4", seg4, e.seg);
                checkOutput("seg_b0", seg0, e.seg);
                checkOutput("dp_b4",  {6'b0, dp4}, {6'b0, e.dp});
                checkOutput("dp_b0",  {6'b0, dp0}, {6'b0, e.dp});
            end
        end
    end

    initial begin
        logic [3:0] cur;
        logic [3:0] sel;
        int         hold;
        rst       = 1'b0;
        digit_sel = 4'b1110;
        value     = '0;
        dp_in     = '0;
        load      = 1'b0;
        modelReset();
        #2;
        doReset();

        // Power-up frames showing zero
        fullFrame(6);
        fullFrame(6);

        // Load during digit2: the rest of this frame keeps the old value
        holdDigit(4'b1110, 6);
        holdDigit(4'b1101, 6);
        holdDigit(4'b1011, 2);
        applyStimulus(4'b1011, 16'h1234, 4'b0010, 1'b1);
        holdDigit(4'b1011, 3);
        holdDigit(4'b0111, 6);
        fullFrame(6);

        // Load coinciding with the commit edge
        holdDigit(4'b1110, 6);
        holdDigit(4'b1101, 6);
        holdDigit(4'b1011, 6);
        applyStimulus(4'b0111, 16'hAAAA, 4'b0101, 1'b1);
        holdDigit(4'b0111, 5);
        applyStimulus(4'b1110, 16'h5555, 4'b1010, 1'b1);
        holdDigit(4'b1110, 5);
        holdDigit(4'b1101, 6);
        holdDigit(4'b1011, 6);
        holdDigit(4'b0111, 6);
        fullFrame(6);

        // Invalid select in the middle of a frame, then resume
        holdDigit(4'b1110, 6);
        holdDigit(4'b1100, 3);
        holdDigit(4'b1101, 6);
        holdDigit(4'b1011, 6);
        holdDigit(4'b0111, 6);

        // Leading-zero pattern
        applyStimulus(4'b0111, 16'h0007, 4'b0000, 1'b1);
        fullFrame(6);
        fullFrame(6);

        // Short holds: digits that never light on the blanked copy
        fullFrame(2);
        fullFrame(5);

        // Reset inside a blanking window
        holdDigit(4'b1110, 6);
        applyStimulus(4'b1101, 16'h0, 4'h0, 1'b0);
        doReset();
        fullFrame(6);

        // Randomised scanning with random loads and glitches
        cur = 4'b1110;
        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 9) == 0) begin
                sel = 4'($urandom);
            end else begin
                case (cur)
                    4'b1110, 4'b1101, 4'b1011, 4'b0111: sel = {cur[2:0], cur[3]};
                    default: sel = 4'b1110;
                endcase
            end
            cur  = sel;
            hold = $urandom_range(1, 8);
            for (int c = 0; c < hold; c++)
                applyStimulus(sel, 16'($urandom), 4'($urandom),
                              1'($urandom_range(0, 15) == 0));
            if (s == 150) doReset();
        end

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0",
                     exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
